branch_recovery_ctrl: RTL and testbench
=======================================

// Module: branch_recovery_ctrl
// PURPOSE
//   Sequences branch retirement and misprediction recovery from the head of the control buffer.
//   Sits between the control buffer, ROB commit, rename (RAT restore from RRAT), LSQ drain and fetch redirect.
//   On a correct branch: dequeues the control-buffer head in the same cycle.
//   On a mispredict: blocks commit, then runs flush -> drain -> RAT restore -> fetch redirect.
// PARAMETERS
//   ROB_IDX        5    width of ROB ids
//   ARCH_REGS      32   architectural registers restored from RRAT
//   RESTORE_WIDTH  4    arch regs restored per cycle; ARCH_REGS % RESTORE_WIDTH must be 0 (checked at elaboration)
// PORTS
//   clk               in   1        clock
//   rst               in   1        reset: synchronous, active-high
//   rob_br_commit     in   1        ROB head is a completed branch eligible to commit; never depends on stall_commit
//   rob_head_id       in   ROB_IDX  ROB id at commit head
//   cb_ready          in   1        control-buffer head entry resolved by the branch CDB
//   cb_rob_id         in   ROB_IDX  control-buffer head rob_id
//   cb_miss_predict   in   1        head branch mispredicted
//   cb_target         in   32       head branch correct target
//   cb_dequeue        out  1        pop control-buffer head this cycle
//   stall_commit      out  1        ROB must not commit this cycle
//   flush             out  1        squash all speculative state (one-cycle pulse)
//   mem_idle          in   1        LSQ has no outstanding memory requests
//   rat_restore       out  1        copy RRAT->RAT for group rat_restore_base..+RESTORE_WIDTH-1
//   rat_restore_base  out  $clog2(ARCH_REGS)  first arch reg of the current group
//   redirect_valid    out  1        fetch redirect request
//   redirect_pc       out  32       redirect target
//   fe_ready          in   1        fetch accepts redirect
//   stat_mispredicts  out  32       mispredict count (see CONFIGURATION)
//   stat_recov_cycles out  32       cycles spent outside IDLE (see CONFIGURATION)
// BEHAVIOUR
//   States: IDLE, FLUSH, DRAIN, RESTORE, REDIRECT. Reset -> IDLE; all outputs 0; target reg 0; restore counter 0.
//   match = cb_ready && (cb_rob_id == rob_head_id).
//   IDLE (combinational outputs):
//     rob_br_commit && !match -> stall_commit=1, no dequeue; stay IDLE.
//     rob_br_commit && match && !cb_miss_predict -> cb_dequeue=1, stall_commit=0; stay IDLE.
//     rob_br_commit && match && cb_miss_predict -> cb_dequeue=1, stall_commit=0 (branch itself commits);
//       latch cb_target; next state FLUSH.
//     !rob_br_commit -> cb_dequeue=0, stall_commit=0.
//   FLUSH: flush=1 for exactly this cycle -> DRAIN.
//   DRAIN: wait until mem_idle=1. mem_idle sampled in DRAIN -> RESTORE with counter=0
//     (minimum 1 DRAIN cycle).
//   RESTORE: rat_restore=1, rat_restore_base = counter*RESTORE_WIDTH.
//     Counter increments each cycle; after group ARCH_REGS/RESTORE_WIDTH-1 -> REDIRECT.
//     Default config: 8 cycles.
//   REDIRECT: redirect_valid=1, redirect_pc=latched target; both held stable until fe_ready.
//     The cycle with fe_ready=1 is the handshake cycle; next state IDLE.
//   stall_commit=1 and cb_dequeue=0 in every non-IDLE state, regardless of rob_br_commit.
//   Latency, mispredict commit to redirect_valid (mem_idle already 1):
//     1 (FLUSH) + 1 (DRAIN) + ARCH_REGS/RESTORE_WIDTH cycles.
//   Latched target is not updated outside IDLE; CB head changes during recovery are ignored.
//   rst asserted in any state -> IDLE next cycle, all outputs 0; no partial restore/redirect completes.
//   Outputs are combinational from state + inputs; no input-to-output path except in IDLE.
// CONFIGURATION
//   BR_RECOVERY_STATS_EN defined:
//     stat_mispredicts +1 on each IDLE->FLUSH transition.
//     stat_recov_cycles +1 every cycle state != IDLE.
//     Both wrap at 2^32; both cleared by rst.
//   Not defined: both stat ports tied to 0; no counter flops.
// TESTING
//   Correct branch: rob_br_commit=1, match, miss=0 -> cb_dequeue=1 same cycle, stall_commit=0, state stays IDLE.
//   Unresolved head: cb_ready=0 for 3 cycles, then 1, miss=0 -> stall_commit=1 for 3 cycles, then cb_dequeue=1.
//   Mispredict to 0x8000_0040, mem_idle=1, fe_ready=1:
//     flush at T+1; rat_restore T+3..T+10 with base 0,4,..,28; redirect_valid T+11, pc=0x8000_0040.
//   Drain hold: mem_idle=0 for 5 cycles after flush -> 5 extra DRAIN cycles, no rat_restore until mem_idle=1.
//   Redirect backpressure: fe_ready=0 for 4 cycles -> redirect_valid/pc stable, stall_commit=1 throughout.
//   Reset mid-RESTORE (after group 2):
//     next cycle all outputs 0, IDLE.
//     A new mispredict restarts restore at base 0.
//     With BR_RECOVERY_STATS_EN, stats read 0 after rst.

Source files
------------

// File: rtl/branch_recovery_ctrl.sv
// Branch retirement and misprediction recovery sequencer for the control-buffer head.
// Latency: correct branch dequeues same cycle; mispredict -> redirect_valid after 2 + ARCH_REGS/RESTORE_WIDTH cycles (mem_idle high).
// Backpressure: holds in DRAIN until mem_idle, holds redirect until fe_ready; commit is stalled throughout recovery.
// Optional build macro: BR_RECOVERY_STATS_EN enables the mispredict / recovery-cycle counters.
module branch_recovery_ctrl #(
    parameter int ROB_IDX       = 5,
    parameter int ARCH_REGS     = 32,
    parameter int RESTORE_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rob_br_commit,
    input  logic [ROB_IDX-1:0]            rob_head_id,
    input  logic                          cb_ready,
    input  logic [ROB_IDX-1:0]            cb_rob_id,
    input  logic                          cb_miss_predict,
    input  logic [31:0]                   cb_target,
    output logic                          cb_dequeue,
    output logic                          stall_commit,
    output logic                          flush,
    input  logic                          mem_idle,
    output logic                          rat_restore,
    output logic [$clog2(ARCH_REGS)-1:0]  rat_restore_base,
    output logic                          redirect_valid,
    output logic [31:0]                   redirect_pc,
    input  logic                          fe_ready,
    output logic [31:0]                   stat_mispredicts,
    output logic [31:0]                   stat_recov_cycles
);

    localparam int GROUPS = ARCH_REGS / RESTORE_WIDTH;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int BASE_W = $clog2(ARCH_REGS);

    // A partial last restore group would leave registers unrestored.
    generate
        if ((ARCH_REGS % RESTORE_WIDTH) != 0) begin : g_width_check
            $error("ARCH_REGS must be a multiple of RESTORE_WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_DRAIN,
        S_RESTORE,
        S_REDIRECT
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match;

    assign match = cb_ready && (cb_rob_id == rob_head_id);

    // State, latched redirect target and restore-group counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and output decode; everything is forced low while rst is high.
    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        cnt_d            = cnt_q;
        cb_dequeue       = 1'b0;
        stall_commit     = 1'b0;
        flush            = 1'b0;
        rat_restore      = 1'b0;
        rat_restore_base = '0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (rob_br_commit) begin
                        if (!match) begin
                            stall_commit = 1'b1;
                        end else begin
                            // The branch itself commits even when it mispredicted.
                            cb_dequeue = 1'b1;
                            if (cb_miss_predict) begin
                                target_d = cb_target;
                                state_d  = S_FLUSH;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    stall_commit = 1'b1;
                    flush        = 1'b1;
                    state_d      = S_DRAIN;
                end
                S_DRAIN: begin
                    stall_commit = 1'b1;
                    if (mem_idle) begin
                        cnt_d   = '0;
                        state_d = S_RESTORE;
                    end
                end
                S_RESTORE: begin
                    stall_commit     = 1'b1;
                    rat_restore      = 1'b1;
                    rat_restore_base = BASE_W'(int'(cnt_q) * RESTORE_WIDTH);
                    if (cnt_q == CNT_W'(GROUPS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_REDIRECT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_REDIRECT: begin
                    stall_commit   = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                    if (fe_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

`ifdef BR_RECOVERY_STATS_EN
    logic [31:0] mispredicts_q;
    logic [31:0] recov_cycles_q;

    // Free-running, wrapping statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredicts_q  <= '0;
            recov_cycles_q <= '0;
        end else begin
            if (state_q == S_IDLE && state_d == S_FLUSH) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
            if (state_q != S_IDLE) begin
                recov_cycles_q <= recov_cycles_q + 32'd1;
            end
        end
    end

    assign stat_mispredicts  = mispredicts_q;
    assign stat_recov_cycles = recov_cycles_q;
`else
    assign stat_mispredicts  = '0;
    assign stat_recov_cycles = '0;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Randomized + directed bench for branch_recovery_ctrl.
// The reference model holds recovery as a queue of pending actions; expected outputs go to a scoreboard.
// A negedge monitor pops one expected record per cycle and compares it against the DUT.
module tb_branch_recovery_ctrl;

    localparam int ROB_IDX = 5;
    localparam int ARCH_REGS = 32;
    localparam int RW = 4;
    localparam int ACT_FLUSH = -1;
    localparam int ACT_DRAIN = -2;
    localparam int ACT_REDIR = -3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rob_br_commit = 1'b0;
    logic [4:0]  rob_head_id = '0;
    logic        cb_ready = 1'b0;
    logic [4:0]  cb_rob_id = '0;
    logic        cb_miss_predict = 1'b0;
    logic [31:0] cb_target = '0;
    logic        mem_idle = 1'b0;
    logic        fe_ready = 1'b0;
    logic        cb_dequeue, stall_commit, flush, rat_restore, redirect_valid;
    logic [4:0]  rat_restore_base;
    logic [31:0] redirect_pc, stat_mispredicts, stat_recov_cycles;

    typedef struct packed {
        logic        deq;
        logic        stall;
        logic        flush;
        logic        restore;
        logic [4:0]  base;
        logic        redir;
        logic [31:0] pc;
        logic [31:0] smis;
        logic [31:0] srec;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int          pending[$];
    logic [31:0] m_target = '0;
    logic [31:0] m_mis = '0;
    logic [31:0] m_rec = '0;

    branch_recovery_ctrl #(.ROB_IDX(ROB_IDX), .ARCH_REGS(ARCH_REGS), .RESTORE_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .rob_br_commit(rob_br_commit), .rob_head_id(rob_head_id),
        .cb_ready(cb_ready), .cb_rob_id(cb_rob_id),
        .cb_miss_predict(cb_miss_predict), .cb_target(cb_target),
        .cb_dequeue(cb_dequeue), .stall_commit(stall_commit), .flush(flush),
        .mem_idle(mem_idle),
        .rat_restore(rat_restore), .rat_restore_base(rat_restore_base),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fe_ready(fe_ready),
        .stat_mispredicts(stat_mispredicts), .stat_recov_cycles(stat_recov_cycles)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic r, input logic c, input logic [4:0] hd, input logic rdy,
                        input logic [4:0] id, input logic miss, input logic [31:0] tgt,
                        input logic mi, input logic fe);
        obs_t e;
        @(posedge clk);
        #1;
        rst = r; rob_br_commit = c; rob_head_id = hd; cb_ready = rdy; cb_rob_id = id;
        cb_miss_predict = miss; cb_target = tgt; mem_idle = mi; fe_ready = fe;
        e = '0;
        if (!r) begin
            e.smis = m_mis;
            e.srec = m_rec;
            if (pending.size() == 0) begin
                if (c && rdy && id == hd) begin
                    e.deq = 1'b1;
                    if (miss) begin
                        m_target = tgt;
                        pending.push_back(ACT_FLUSH);
                        pending.push_back(ACT_DRAIN);
                        for (int g = 0; g < ARCH_REGS / RW; g++) pending.push_back(g);
                        pending.push_back(ACT_REDIR);
                        m_mis = m_mis + 32'd1;
                    end
                end else if (c) begin
                    e.stall = 1'b1;
                end
            end else begin
                m_rec = m_rec + 32'd1;
                e.stall = 1'b1;
                if (pending[0] == ACT_FLUSH) begin
                    e.flush = 1'b1;
                    void'(pending.pop_front());
                end else if (pending[0] == ACT_DRAIN) begin
                    if (mi) void'(pending.pop_front());
                end else if (pending[0] == ACT_REDIR) begin
                    e.redir = 1'b1;
                    e.pc = m_target;
                    if (fe) void'(pending.pop_front());
                end else begin
                    e.restore = 1'b1;
                    e.base = 5'(pending[0] * RW);
                    void'(pending.pop_front());
                end
            end
`ifndef BR_RECOVERY_STATS_EN
            e.smis = '0;
            e.srec = '0;
`endif
        end else begin
            pending.delete();
            m_target = '0;
            m_mis = '0;
            m_rec = '0;
        end
        sb.push_back(e);
    endtask

    // Monitor: compare DUT outputs with the oldest expected record.
    always @(negedge clk) begin
        obs_t a, e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{cb_dequeue, stall_commit, flush, rat_restore, rat_restore_base,
                  redirect_valid, redirect_pc, stat_mispredicts, stat_recov_cycles};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got deq=%b stall=%b flush=%b rst=%b base=%0d rv=%b pc=%h smis=%0d srec=%0d expected deq=%b stall=%b flush=%b rst=%b base=%0d rv=%b pc=%h smis=%0d srec=%0d",
                         $time, a.deq, a.stall, a.flush, a.restore, a.base, a.redir, a.pc, a.smis, a.srec,
                         e.deq, e.stall, e.flush, e.restore, e.base, e.redir, e.pc, e.smis, e.srec);
            end
        end
    end

    task automatic idle_cycles(input int n, input logic mi, input logic fe);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 32'hDEAD_BEEF, mi, fe);
    endtask

    task automatic mispredict(input logic [31:0] tgt, input logic mi, input logic fe);
        step(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, tgt, mi, fe);
    endtask

    initial begin
        // Reset, then reset state with quiet inputs
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 32'h1234, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Correct branch
        step(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 32'h0, 1'b1, 1'b1);
        // Unresolved head for 3 cycles, id mismatch once, then resolved
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd4, 1'b0, 5'd4, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'd4, 1'b1, 5'd5, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 32'h0, 1'b1, 1'b1);

        // Mispredict with clean memory and ready fetch
        mispredict(32'h8000_0040, 1'b1, 1'b1);
        idle_cycles(12, 1'b1, 1'b1);

        // Drain hold: memory busy through flush and 5 drain cycles
        mispredict(32'h8000_1000, 1'b0, 1'b1);
        idle_cycles(6, 1'b0, 1'b1);
        idle_cycles(11, 1'b1, 1'b1);

        // Redirect backpressure
        mispredict(32'h0000_ABC0, 1'b1, 1'b0);
        idle_cycles(14, 1'b1, 1'b0);
        idle_cycles(2, 1'b1, 1'b1);

        // Reset after restore group 2, then a fresh recovery
        mispredict(32'h1111_2220, 1'b1, 1'b1);
        idle_cycles(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 32'h5555_0000, 1'b1, 1'b1);
        idle_cycles(2, 1'b1, 1'b1);
        mispredict(32'h2222_3330, 1'b1, 1'b1);
        idle_cycles(12, 1'b1, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] hd;
            logic [4:0] id;
            hd = 5'($urandom_range(0, 31));
            id = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : hd;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), hd,
                 ($urandom_range(0, 3) != 0), id, ($urandom_range(0, 4) == 0),
                 $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1));
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
